alu_fu_pool: RTL and testbench
==============================

# alu_fu_pool

Parametrised pool of `NUM_UNITS` integer ALU lanes for the out-of-order core, sitting between the ALU reservation station and the CDB arbiter. Each lane executes one RV32I integer op per cycle and buffers results in its own FIFO of depth `QUEUE_DEPTH`. A round-robin arbiter presents one buffered result at a time on a ready/valid CDB port. A flush input discards all in-flight work on mispredict recovery.

## Interface
- `NUM_UNITS`, default 2: number of ALU lanes, 1 to 8.
- `QUEUE_DEPTH`, default 4: entries per lane result FIFO; power of two, at least 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous reset, active-low.
- `flush`  in  1  synchronous discard of all lane state.
- `issue_valid`  in  NUM_UNITS  per-lane issue request.
- `issue_op`  in  NUM_UNITS x $bits(rs_to_alu_t)  per-lane op, including pc, imm, funct3/7, opcode, rd, pd, rob_entry_idx.
- `ps1_value`, `ps2_value`  in  NUM_UNITS x 32  per-lane source operands.
- `issue_ready`  out  NUM_UNITS  lane can accept an op this cycle.
- `cdb_valid`  out  1  `cdb_entry` holds a result.
- `cdb_ready`  in  1  arbiter takes `cdb_entry` this cycle.
- `cdb_entry`  out  $bits(cdb_entry_t)  selected result.
- `lane_count`  out  NUM_UNITS x ($clog2(QUEUE_DEPTH)+1)  per-lane FIFO occupancy.

## Operation
- An issue is accepted on lane i when `issue_valid[i] && issue_ready[i]` at a rising edge.
- Operand b is `imm` for `op_b_imm` and `ps2_value` otherwise.
- Ops: add/sub (sub only for `op_b_reg` with funct7[5]=1), sll, slt signed, sltu unsigned, xor, srl/sra by funct7[5], or, and.
  - Shift amount is b[4:0].
  - slt/slti compare signed; sltu/sltiu compare unsigned.
- `op_b_lui` gives `imm`; `op_b_auipc` gives `pc + imm`. Any other opcode gives value 0, and the entry is still written.
- Result entry: value, rd, pd, rob_entry_idx, opcode, pc, rs1_value=a, rs2_value=b, calculated_pc_next=pc+4, valid=1, all mem_* fields 0.
- All 32-bit arithmetic wraps modulo 2^32.
- Lane FIFO: `issue_ready[i]` = occupancy + in-flight stage < QUEUE_DEPTH.
  - Ready does not look ahead to a same-cycle dequeue: a full FIFO stays not-ready even while being drained.
  - Read and write pointers wrap modulo QUEUE_DEPTH.
- Arbiter: round-robin pointer `rr_ptr`.
  - The winner is the first non-empty lane starting at `rr_ptr`, searching upward with wrap.
  - `cdb_valid` = any lane non-empty. `cdb_entry` = head of the winner, combinational from registers. Outputs 0 when no lane is non-empty.
  - On `cdb_valid && cdb_ready`, the winner FIFO pops and `rr_ptr` becomes winner+1 mod NUM_UNITS. Otherwise `rr_ptr` holds.
- Same lane, same edge, enqueue and dequeue: both take effect and the count is unchanged.
- `flush`:
  - Empties all FIFOs and in-flight stages and resets pointers and `rr_ptr` to 0.
  - Issues presented in the flush cycle are dropped.
  - A `cdb_ready` in the flush cycle is ignored.

## Timing
- Reset (`rst_n`=0 at an edge): all FIFOs empty, `rr_ptr`=0, in-flight stages invalid.
  - Reset wins over flush and issue.
  - Reset mid-operation discards everything.
- Outputs after reset: `cdb_valid`=0, `cdb_entry`=0, `lane_count`=0, `issue_ready`=all ones.
- Latency without pipe stage: accepted at edge N, result visible on `cdb_valid` in cycle N+1 if it wins arbitration.
- Throughput: 1 op per lane per cycle; 1 result per cycle onto the CDB.
- `cdb_entry` is stable while `cdb_valid=1 && cdb_ready=0`.

## Configuration
- `ALU_FU_PIPE_EN` defined:
  - Each lane registers its ALU result in one execute stage before the FIFO, so latency is 2 cycles (accept at N, visible N+2).
  - The stage counts toward `issue_ready` occupancy.
- Undefined: the ALU writes the FIFO directly at the accept edge; latency is 1 cycle.

## Test plan
- Reset then single add on lane 0: ps1=5, ps2=7, funct3=add, `op_b_reg` -> `cdb_valid` next cycle (pipe: +1), value 12, calculated_pc_next=pc+4; `cdb_ready`=1 pops, and `cdb_valid`=0 after.
- Signed/unsigned/shift: slt with ps1=0xFFFFFFFF, ps2=1 -> 1; sltu on the same -> 0; slti with imm=0xFFFFFFFF, ps1=0 -> 0; sra 0x80000000 by 4 -> 0xF8000000; srl -> 0x08000000; sub 3-5 -> 0xFFFFFFFE.
- Backpressure with QUEUE_DEPTH=4, `cdb_ready`=0:
  - Issue 5 ops on lane 1 -> `issue_ready[1]`=0 after the 4th, `lane_count[1]`=4, and the 5th is not accepted.
  - Then `cdb_ready`=1 -> results are drained in issue order.
- Fairness with NUM_UNITS=2, both lanes holding 3 entries, `cdb_ready`=1 -> CDB order is lane 0, 1, 0, 1, 0, 1.
- Flush mid-stream with 2 entries per lane plus a concurrent issue -> next cycle all counts are 0, `cdb_valid`=0, and the dropped issue never appears.
- Assert `rst_n`=0 while FIFOs are full -> after the edge all outputs hold their reset values.

Source files
------------

// File: rtl/alu_fu_pool.sv
// Pool of RV32I integer ALU lanes with per-lane result FIFOs and a round-robin CDB arbiter.
// Optional macro ALU_FU_PIPE_EN adds one registered execute stage per lane in front of its FIFO.
package alu_fu_pkg;
    localparam logic [2:0] op_b_reg   = 3'd0;
    localparam logic [2:0] op_b_imm   = 3'd1;
    localparam logic [2:0] op_b_lui   = 3'd2;
    localparam logic [2:0] op_b_auipc = 3'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [2:0]  opcode;
        logic [4:0]  rd;
        logic [5:0]  pd;
        logic [4:0]  rob_entry_idx;
    } rs_to_alu_t;

    typedef struct packed {
        logic [31:0] value;
        logic [4:0]  rd;
        logic [5:0]  pd;
        logic [4:0]  rob_entry_idx;
        logic [2:0]  opcode;
        logic [31:0] pc;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
        logic [31:0] calculated_pc_next;
        logic        valid;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        mem_we;
        logic [1:0]  mem_size;
    } cdb_entry_t;
endpackage

module alu_fu_pool
    import alu_fu_pkg::*;
#(
    parameter int NUM_UNITS   = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          flush,
    input  logic [NUM_UNITS-1:0]                          issue_valid,
    input  rs_to_alu_t [NUM_UNITS-1:0]                    issue_op,
    input  logic [NUM_UNITS-1:0][31:0]                    ps1_value,
    input  logic [NUM_UNITS-1:0][31:0]                    ps2_value,
    output logic [NUM_UNITS-1:0]                          issue_ready,
    output logic                                          cdb_valid,
    input  logic                                          cdb_ready,
    output cdb_entry_t                                    cdb_entry,
    output logic [NUM_UNITS-1:0][$clog2(QUEUE_DEPTH):0]   lane_count
);
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int CW = QW + 1;
    localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    // Handshake: an issue moves on lane i when issue_valid[i] && issue_ready[i] at a rising
    // edge; a CDB result moves when cdb_valid && cdb_ready; valid never depends on ready.
    function automatic cdb_entry_t alu_exec(input rs_to_alu_t op, input logic [31:0] a,
                                            input logic [31:0] rs2);
        cdb_entry_t e;
        logic [31:0] b;
        logic [4:0]  sh;
        e  = '0;
        b  = (op.opcode == op_b_imm) ? op.imm : rs2;
        sh = b[4:0];
        case (op.opcode)
            op_b_reg, op_b_imm: begin
                case (op.funct3)
                    3'd0: e.value = (op.opcode == op_b_reg && op.funct7[5]) ? a - b : a + b;
                    3'd1: e.value = a << sh;
                    3'd2: e.value = {31'd0, $signed(a) < $signed(b)};
                    3'd3: e.value = {31'd0, a < b};
                    3'd4: e.value = a ^ b;
                    3'd5: begin
                        // Kept as an if: inside ?: the unsigned srl arm would make sra logical.
                        if (op.funct7[5]) e.value = $signed(a) >>> sh;
                        else              e.value = a >> sh;
                    end
                    3'd6: e.value = a | b;
                    default: e.value = a & b;
                endcase
            end
            op_b_lui:   e.value = op.imm;
            op_b_auipc: e.value = op.pc + op.imm;
            default:    e.value = 32'd0;
        endcase
        e.rd                 = op.rd;
        e.pd                 = op.pd;
        e.rob_entry_idx      = op.rob_entry_idx;
        e.opcode             = op.opcode;
        e.pc                 = op.pc;
        e.rs1_value          = a;
        e.rs2_value          = b;
        e.calculated_pc_next = op.pc + 32'd4;
        e.valid              = 1'b1;
        return e;
    endfunction

    cdb_entry_t                   alu_result [NUM_UNITS];
    cdb_entry_t                   wr_data    [NUM_UNITS];
    cdb_entry_t                   fifo_mem   [NUM_UNITS][QUEUE_DEPTH];
    logic [NUM_UNITS-1:0]         accept, wr_en, pop;
    logic [NUM_UNITS-1:0][CW-1:0] count;
    logic [NUM_UNITS-1:0][QW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0]                rr_ptr, winner, rr_next, cand;
    logic [PW:0]                  sum;
    logic                         found;
    logic                         unused_funct7;

    always_comb begin
        unused_funct7 = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            alu_result[i] = alu_exec(issue_op[i], ps1_value[i], ps2_value[i]);
            unused_funct7 = unused_funct7 ^ (^{issue_op[i].funct7[6], issue_op[i].funct7[4:0]});
        end
    end

`ifdef ALU_FU_PIPE_EN
    logic [NUM_UNITS-1:0] pipe_valid;
    cdb_entry_t           pipe_entry [NUM_UNITS];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) pipe_valid <= '0;
        else                 pipe_valid <= accept;
        for (int i = 0; i < NUM_UNITS; i++)
            if (accept[i]) pipe_entry[i] <= alu_result[i];
    end

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            issue_ready[i] = ({1'b0, count[i]} + {{CW{1'b0}}, pipe_valid[i]}) < (CW+1)'(QUEUE_DEPTH);
            accept[i]      = issue_valid[i] && issue_ready[i];
            wr_en[i]       = pipe_valid[i];
            wr_data[i]     = pipe_entry[i];
            lane_count[i]  = count[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            issue_ready[i] = {1'b0, count[i]} < (CW+1)'(QUEUE_DEPTH);
            accept[i]      = issue_valid[i] && issue_ready[i];
            wr_en[i]       = accept[i];
            wr_data[i]     = alu_result[i];
            lane_count[i]  = count[i];
        end
    end
`endif

    // Winner is the first non-empty lane at or above rr_ptr, wrapping once.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        cand   = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NUM_UNITS)) sum = sum - (PW+1)'(NUM_UNITS);
            cand = sum[PW-1:0];
            if (!found && count[cand] != '0) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        cdb_valid = found;
        cdb_entry = found ? fifo_mem[winner][rd_ptr[winner]] : '0;
        rr_next   = (winner == PW'(NUM_UNITS - 1)) ? '0 : winner + PW'(1);
        for (int i = 0; i < NUM_UNITS; i++)
            pop[i] = found && cdb_ready && (winner == PW'(i));
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + QW'(1);
                if (pop[i])   rd_ptr[i] <= rd_ptr[i] + QW'(1);
                if (wr_en[i] && !pop[i])      count[i] <= count[i] + CW'(1);
                else if (!wr_en[i] && pop[i]) count[i] <= count[i] - CW'(1);
            end
            if (cdb_valid && cdb_ready) rr_ptr <= rr_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_UNITS; i++)
            if (rst_n && !flush && wr_en[i]) fifo_mem[i][wr_ptr[i]] <= wr_data[i];
    end
endmodule

// File: tb/tb_alu_fu_pool.sv
// Bench for alu_fu_pool: ALU vector table, hand-written FIFO/arbiter/flush/reset sequences,
// and randomized traffic compared every cycle against a queue-based reference model.
module tb_alu_fu_pool;
    import alu_fu_pkg::*;

    localparam int N  = 2;
    localparam int QD = 4;
`ifdef ALU_FU_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                clk;
    logic                rst_n;
    logic                flush;
    logic [N-1:0]        issue_valid;
    rs_to_alu_t [N-1:0]  issue_op;
    logic [N-1:0][31:0]  ps1_value;
    logic [N-1:0][31:0]  ps2_value;
    logic [N-1:0]        issue_ready;
    logic                cdb_valid;
    logic                cdb_ready;
    cdb_entry_t          cdb_entry;
    logic [N-1:0][2:0]   lane_count;

    alu_fu_pool #(.NUM_UNITS(N), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .ps1_value(ps1_value), .ps2_value(ps2_value),
        .issue_ready(issue_ready), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .cdb_entry(cdb_entry), .lane_count(lane_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    bit model_on;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: one queue per lane holding completed results, plus an optional
    // one-deep execute stage, and a round-robin start lane.
    cdb_entry_t mq [N][$];
    bit         pv [N];
    cdb_entry_t pe [N];
    int         rr;

    function automatic cdb_entry_t ref_alu(input rs_to_alu_t op, input logic [31:0] a,
                                           input logic [31:0] rs2);
        cdb_entry_t e;
        logic [31:0] b;
        int          sh;
        e  = '0;
        b  = (op.opcode == op_b_imm) ? op.imm : rs2;
        sh = int'(b % 32);
        if (op.opcode == op_b_reg || op.opcode == op_b_imm) begin
            if (op.funct3 == 3'd0 && op.opcode == op_b_reg && op.funct7[5]) e.value = a - b;
            else if (op.funct3 == 3'd0) e.value = a + b;
            else if (op.funct3 == 3'd1) e.value = a << sh;
            else if (op.funct3 == 3'd2) e.value = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            else if (op.funct3 == 3'd3) e.value = (a < b) ? 32'd1 : 32'd0;
            else if (op.funct3 == 3'd4) e.value = a ^ b;
            else if (op.funct3 == 3'd5 && op.funct7[5]) e.value = 32'(int'(a) >>> sh);
            else if (op.funct3 == 3'd5) e.value = a >> sh;
            else if (op.funct3 == 3'd6) e.value = a | b;
            else e.value = a & b;
        end else if (op.opcode == op_b_lui) begin
            e.value = op.imm;
        end else if (op.opcode == op_b_auipc) begin
            e.value = op.pc + op.imm;
        end
        e.rd = op.rd;
        e.pd = op.pd;
        e.rob_entry_idx = op.rob_entry_idx;
        e.opcode = op.opcode;
        e.pc = op.pc;
        e.rs1_value = a;
        e.rs2_value = b;
        e.calculated_pc_next = op.pc + 32'd4;
        e.valid = 1'b1;
        return e;
    endfunction

    function automatic int model_winner();
        for (int k = 0; k < N; k++)
            if (mq[(rr + k) % N].size() > 0) return (rr + k) % N;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            pv[i] = 1'b0;
        end
        rr = 0;
    endtask

    task automatic check_outputs();
        int w;
        w = model_winner();
        for (int i = 0; i < N; i++) begin
            check("issue_ready", issue_ready[i], (mq[i].size() + int'(pv[i])) < QD);
            check("lane_count", lane_count[i], mq[i].size());
        end
        check("cdb_valid", cdb_valid, w >= 0);
        check("cdb_entry", cdb_entry, (w >= 0) ? mq[w][0] : cdb_entry_t'('0));
    endtask

    task automatic model_step();
        int w;
        bit acc [N];
        if (!rst_n || flush) begin
            model_clear();
        end else begin
            w = model_winner();
            for (int i = 0; i < N; i++)
                acc[i] = issue_valid[i] && ((mq[i].size() + int'(pv[i])) < QD);
            if (w >= 0 && cdb_ready) begin
                void'(mq[w].pop_front());
                rr = (w + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (LAT == 2) begin
                    if (pv[i]) mq[i].push_back(pe[i]);
                    pv[i] = acc[i];
                    if (acc[i]) pe[i] = ref_alu(issue_op[i], ps1_value[i], ps2_value[i]);
                end else if (acc[i]) begin
                    mq[i].push_back(ref_alu(issue_op[i], ps1_value[i], ps2_value[i]));
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (model_on) check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic rs_to_alu_t make_op(input logic [2:0] opc, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] imm,
                                           input logic [31:0] pc, input logic [4:0] rd);
        rs_to_alu_t o;
        o = '0;
        o.opcode = opc;
        o.funct3 = f3;
        o.funct7 = f7;
        o.imm = imm;
        o.pc = pc;
        o.rd = rd;
        o.pd = {1'b0, rd} ^ 6'h2A;
        o.rob_entry_idx = rd ^ 5'h15;
        return o;
    endfunction

    typedef struct {
        logic [2:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];
    int   fair_rd [6];

    initial begin
        vecs[0]  = '{op_b_reg,   3'd0, 7'h00, 32'd5,         32'd7,  32'd0,         32'h100,  32'd12};
        vecs[1]  = '{op_b_reg,   3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1,  32'd0,         32'h104,  32'd1};
        vecs[2]  = '{op_b_reg,   3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1,  32'd0,         32'h108,  32'd0};
        vecs[3]  = '{op_b_imm,   3'd2, 7'h7F, 32'd0,         32'd5,  32'hFFFF_FFFF, 32'h10C,  32'd0};
        vecs[4]  = '{op_b_reg,   3'd5, 7'h20, 32'h8000_0000, 32'd4,  32'd0,         32'h110,  32'hF800_0000};
        vecs[5]  = '{op_b_reg,   3'd5, 7'h00, 32'h8000_0000, 32'd4,  32'd0,         32'h114,  32'h0800_0000};
        vecs[6]  = '{op_b_reg,   3'd0, 7'h20, 32'd3,         32'd5,  32'd0,         32'h118,  32'hFFFF_FFFE};
        vecs[7]  = '{op_b_imm,   3'd0, 7'h20, 32'd10,        32'd99, 32'd3,         32'h11C,  32'd13};
        vecs[8]  = '{op_b_lui,   3'd0, 7'h00, 32'd1,         32'd2,  32'h1234_5000, 32'h120,  32'h1234_5000};
        vecs[9]  = '{op_b_auipc, 3'd0, 7'h00, 32'd1,         32'd2,  32'h2000,      32'h1000, 32'h3000};
        vecs[10] = '{3'd4,       3'd0, 7'h00, 32'd9,         32'd9,  32'd9,         32'h124,  32'd0};
        vecs[11] = '{op_b_reg,   3'd1, 7'h00, 32'd1,         32'h3F, 32'd0,         32'h128,  32'h8000_0000};
        vecs[12] = '{op_b_reg,   3'd4, 7'h00, 32'hF0F0,      32'h0FF0, 32'd0,       32'h12C,  32'hFF00};
        fair_rd = '{1, 9, 2, 10, 3, 11};

        checks = 0; failures = 0; model_on = 1'b0;
        rst_n = 1'b0; flush = 1'b0; cdb_ready = 1'b0;
        issue_valid = '0; issue_op = '0; ps1_value = '0; ps2_value = '0;
        model_clear();
        cycle();
        model_on = 1'b1;
        check("rst_cdb_valid", cdb_valid, 1'b0);
        check("rst_cdb_entry", cdb_entry, 256'd0);
        check("rst_lane_count", lane_count, 6'd0);
        check("rst_issue_ready", issue_ready, 2'b11);
        cycle();
        rst_n = 1'b1;

        // ALU vectors on lane 0, each drained immediately.
        cdb_ready = 1'b1;
        for (int v = 0; v < 13; v++) begin
            issue_valid = 2'b01;
            issue_op[0] = make_op(vecs[v].opc, vecs[v].f3, vecs[v].f7, vecs[v].imm, vecs[v].pc, 5'(v));
            ps1_value[0] = vecs[v].a;
            ps2_value[0] = vecs[v].b;
            cycle();
            issue_valid = '0;
            repeat (LAT - 1) cycle();
            check("vec_valid", cdb_valid, 1'b1);
            check("vec_value", cdb_entry.value, vecs[v].exp);
            check("vec_pc_next", cdb_entry.calculated_pc_next, vecs[v].pc + 32'd4);
            cycle();
            check("vec_drained", cdb_valid, 1'b0);
        end

        // Backpressure: five issues on lane 1 with the CDB stalled.
        cdb_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            issue_valid = 2'b10;
            issue_op[1] = make_op(op_b_reg, 3'd0, 7'h00, 32'd0, 32'h200, 5'(k));
            ps1_value[1] = 32'(k);
            ps2_value[1] = 32'd100;
            cycle();
            if (k == 4) check("bp_ready_after4", issue_ready[1], 1'b0);
        end
        issue_valid = '0;
        cycle();
        check("bp_count_full", lane_count[1], 3'd4);
        check("bp_ready_full", issue_ready[1], 1'b0);
        cdb_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("bp_order_rd", cdb_entry.rd, 5'(k));
            check("bp_order_value", cdb_entry.value, 32'(100 + k));
            cycle();
        end
        check("bp_fifth_dropped", cdb_valid, 1'b0);
        check("bp_count_empty", lane_count[1], 3'd0);

        // Fairness from a known rr_ptr of 0.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cdb_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            issue_valid = 2'b11;
            issue_op[0] = make_op(op_b_reg, 3'd0, 7'h00, 32'd0, 32'h300, 5'(k));
            issue_op[1] = make_op(op_b_reg, 3'd0, 7'h00, 32'd0, 32'h400, 5'(8 + k));
            cycle();
        end
        issue_valid = '0;
        repeat (LAT) cycle();
        cdb_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            check("fair_order", cdb_entry.rd, 5'(fair_rd[j]));
            cycle();
        end
        check("fair_empty", cdb_valid, 1'b0);

        // Flush with two entries per lane and a concurrent issue.
        cdb_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            issue_valid = 2'b11;
            issue_op[0] = make_op(op_b_reg, 3'd0, 7'h00, 32'd0, 32'h500, 5'(k + 1));
            issue_op[1] = make_op(op_b_reg, 3'd0, 7'h00, 32'd0, 32'h600, 5'(k + 9));
            cycle();
        end
        issue_valid = '0;
        repeat (LAT) cycle();
        check("flush_pre_count", lane_count, {3'd2, 3'd2});
        flush = 1'b1;
        cdb_ready = 1'b1;
        issue_valid = 2'b11;
        issue_op[0] = make_op(op_b_reg, 3'd0, 7'h00, 32'd0, 32'h700, 5'd20);
        issue_op[1] = make_op(op_b_reg, 3'd0, 7'h00, 32'd0, 32'h700, 5'd21);
        cycle();
        flush = 1'b0;
        issue_valid = '0;
        cdb_ready = 1'b0;
        check("flush_count", lane_count, 6'd0);
        check("flush_valid", cdb_valid, 1'b0);
        repeat (LAT + 1) cycle();
        check("flush_dropped", cdb_valid, 1'b0);

        // Reset while both FIFOs are full, with flush, issue and cdb_ready all active.
        for (int k = 0; k < 6; k++) begin
            issue_valid = 2'b11;
            issue_op[0] = make_op(op_b_lui, 3'd0, 7'h00, 32'(k), 32'h800, 5'(k));
            issue_op[1] = make_op(op_b_lui, 3'd0, 7'h00, 32'(k), 32'h900, 5'(k + 16));
            cycle();
        end
        issue_valid = '0;
        repeat (LAT) cycle();
        check("full_count", lane_count, {3'd4, 3'd4});
        rst_n = 1'b0;
        flush = 1'b1;
        cdb_ready = 1'b1;
        issue_valid = 2'b11;
        cycle();
        rst_n = 1'b1;
        flush = 1'b0;
        cdb_ready = 1'b0;
        issue_valid = '0;
        check("rstfull_valid", cdb_valid, 1'b0);
        check("rstfull_entry", cdb_entry, 256'd0);
        check("rstfull_count", lane_count, 6'd0);
        check("rstfull_ready", issue_ready, 2'b11);
        repeat (LAT + 1) cycle();
        check("rstfull_quiet", cdb_valid, 1'b0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            flush = ($urandom_range(0, 49) == 0);
            cdb_ready = ($urandom_range(0, 2) != 0);
            issue_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                issue_op[i] = make_op(3'($urandom_range(0, 4)), 3'($urandom), 7'($urandom),
                                      $urandom, $urandom & 32'hFFFF_FFFC, 5'($urandom));
                ps1_value[i] = $urandom;
                ps2_value[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            end
            cycle();
        end
        rst_n = 1'b1;
        flush = 1'b0;
        issue_valid = '0;
        cdb_ready = 1'b1;
        repeat (2 * QD * N + 4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
